// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the counter job issuer
package counter_pkg;

    localparam int CNT_WIDTH_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/counter_job_issuer_if.sv
// rtl/counter_job_issuer_if.sv - job request and response channels
interface counter_job_issuer_if #(
    parameter int CNT_WIDTH = 7,
    parameter int ID_WIDTH  = 4,
    parameter int TO_WIDTH  = 16
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [CNT_WIDTH-1:0] req_cnt_val_i;
    logic [ID_WIDTH-1:0]  req_id_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [ID_WIDTH-1:0]  rsp_id_o;
    logic [TO_WIDTH-1:0]  rsp_cycles_o;
    logic                 rsp_timeout_o;

    // Requester side
    modport master (
        output req_valid_i, req_cnt_val_i, req_id_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_cycles_o, rsp_timeout_o
    );

    // Issuer side
    modport slave (
        input  req_valid_i, req_cnt_val_i, req_id_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_cycles_o, rsp_timeout_o
    );
endinterface

// File: rtl/counter_job_fifo.sv
// rtl/counter_job_fifo.sv - small job FIFO with registered full flag
module counter_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_o;
    assign empty_o = (cnt_q == '0);
    assign full_o  = full_q;
    assign rdata_o = mem_q[rd_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == FULL_CNT);
    end

    // State registers; full reads 1 in reset so the requester sees no ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b1;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end
endmodule

// File: rtl/counter_job_issuer.sv
// rtl/counter_job_issuer.sv - launches queued count jobs and reports their completion
module counter_job_issuer
    import counter_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int ID_WIDTH  = 4,
    parameter int DEPTH     = 4,
    parameter int TO_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_job_issuer_if.slave  job,
    input  logic [TO_WIDTH-1:0]  timeout_lim_i,
    output logic                 cnt_start_o,
    output logic [CNT_WIDTH-1:0] cnt_val_o,
    input  logic                 cnt_idle_i,
    input  logic                 cnt_run_i,
    input  logic                 cnt_done_i,
    output logic                 busy_o
);
    localparam int DW = ID_WIDTH + CNT_WIDTH;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          unused_run;

    state_e                state_q, state_d;
    logic                  start_q, start_d;
    logic [CNT_WIDTH-1:0]  val_q, val_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [TO_WIDTH-1:0]   cyc_q, cyc_d, cyc_inc;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [TO_WIDTH-1:0]   rsp_cycles_q, rsp_cycles_d;
    logic                  rsp_to_q, rsp_to_d;

    // Counter run status is informational only
    assign unused_run = cnt_run_i;

    assign fifo_push       = job.req_valid_i & ~fifo_full;
    assign job.req_ready_o = ~fifo_full;

    counter_job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({job.req_id_i, job.req_cnt_val_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Elapsed count including the current WAIT cycle, held at all-ones
    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + TO_WIDTH'(1);

    // Job sequencing: pop, launch, wait for done or watchdog, hold response
    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        val_d        = val_q;
        id_d         = id_q;
        cyc_d        = cyc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_cycles_d = rsp_cycles_q;
        rsp_to_d     = rsp_to_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && cnt_idle_i) begin
                    fifo_pop      = 1'b1;
                    {id_d, val_d} = fifo_rdata;
                    start_d       = 1'b1;
                    state_d       = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cyc_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_done_i) begin
                    rsp_valid_d  = 1'b1;
                    rsp_cycles_d = cyc_inc;
                    rsp_to_d     = 1'b0;
                    state_d      = ST_RESP;
                end else if (timeout_lim_i != '0 && cyc_inc == timeout_lim_i) begin
                    rsp_valid_d  = 1'b1;
                    rsp_cycles_d = timeout_lim_i;
                    rsp_to_d     = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
            ST_RESP: begin
                if (job.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            val_q        <= '0;
            id_q         <= '0;
            cyc_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_cycles_q <= '0;
            rsp_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            val_q        <= val_d;
            id_q         <= id_d;
            cyc_q        <= cyc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_cycles_q <= rsp_cycles_d;
            rsp_to_q     <= rsp_to_d;
        end
    end

    assign cnt_start_o       = start_q;
    assign cnt_val_o         = val_q;
    assign job.rsp_valid_o   = rsp_valid_q;
    assign job.rsp_id_o      = id_q;
    assign job.rsp_cycles_o  = rsp_cycles_q;
    assign job.rsp_timeout_o = rsp_to_q;
    assign busy_o            = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_counter_job_issuer.sv
// tb/tb_counter_job_issuer.sv - scoreboard bench for counter_job_issuer
module tb_counter_job_issuer;
    localparam int CW = 7;
    localparam int IW = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] timeout_lim_i;
    logic          cnt_start_o;
    logic [CW-1:0] cnt_val_o;
    logic          cnt_idle_i, cnt_run_i;
    logic          cnt_done_i = 1'b0;
    logic          busy_o;

    always #5 clk = ~clk;

    counter_job_issuer_if #(.CNT_WIDTH(CW), .ID_WIDTH(IW), .TO_WIDTH(TW)) job_if ();

    counter_job_issuer #(.CNT_WIDTH(CW), .ID_WIDTH(IW), .DEPTH(4), .TO_WIDTH(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .job           (job_if),
        .timeout_lim_i (timeout_lim_i),
        .cnt_start_o   (cnt_start_o),
        .cnt_val_o     (cnt_val_o),
        .cnt_idle_i    (cnt_idle_i),
        .cnt_run_i     (cnt_run_i),
        .cnt_done_i    (cnt_done_i),
        .busy_o        (busy_o)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [TW-1:0] cycles;
        logic          tmo;
    } rsp_t;

    rsp_t          exp_rsp[$];
    logic [CW-1:0] exp_val[$];
    int errors = 0;
    int checks = 0;
    int n_starts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Counter model: done arrives m_dly cycles after start, idle returns the cycle after done
    int   m_dly = 6;
    int   m_rem = 0;
    logic m_idle = 1'b1;
    logic m_st, m_was_done;
    logic hold = 1'b0;
    assign cnt_idle_i = m_idle & ~hold;
    assign cnt_run_i  = ~m_idle;

    always begin
        @(posedge clk);
        m_st = cnt_start_o;
        #1;
        m_was_done = cnt_done_i;
        cnt_done_i = 1'b0;
        if (m_was_done) m_idle = 1'b1;
        if (m_st) begin
            m_idle = 1'b0;
            m_rem  = m_dly - 1;
            if (m_rem == 0) cnt_done_i = 1'b1;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) cnt_done_i = 1'b1;
        end
    end

    // Monitor: compares launches and accepted responses against the scoreboard
    logic idle_prev = 1'b1;
    always @(negedge clk) begin
        rsp_t          e;
        logic [CW-1:0] v;
        if (!rst) begin
            if (cnt_start_o) begin
                n_starts++;
                chk("start_needs_idle", idle_prev, 1);
                if (exp_val.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got val %0d, expected no start", cnt_val_o);
                end else begin
                    v = exp_val.pop_front();
                    chk("start_val", cnt_val_o, v);
                end
            end
            if (job_if.rsp_valid_o && job_if.rsp_ready_i) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d, expected no response", job_if.rsp_id_o);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_id", job_if.rsp_id_o, e.id);
                    chk("rsp_cycles", job_if.rsp_cycles_o, e.cycles);
                    chk("rsp_timeout", job_if.rsp_timeout_o, e.tmo);
                end
            end
        end
        idle_prev = cnt_idle_i;
    end

    task automatic send(input int id, input int val, input int cyc, input bit tmo,
                        input bit want_rsp, input bit want_start);
        int   n;
        rsp_t r;
        n = 0;
        job_if.req_valid_i   = 1'b1;
        job_if.req_id_i      = id[IW-1:0];
        job_if.req_cnt_val_i = val[CW-1:0];
        r.id = id[IW-1:0];
        r.cycles = cyc[TW-1:0];
        r.tmo = tmo;
        if (want_rsp) exp_rsp.push_back(r);
        if (want_start) exp_val.push_back(val[CW-1:0]);
        @(negedge clk);
        while (!job_if.req_ready_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!job_if.req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_accept id %0d: ready 0, expected 1", id);
        end
        @(posedge clk);
        #1;
        job_if.req_valid_i = 1'b0;
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_val.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_rsp.size() + exp_val.size(), 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        job_if.req_valid_i   = 1'b0;
        job_if.req_id_i      = '0;
        job_if.req_cnt_val_i = '0;
        job_if.rsp_ready_i   = 1'b1;
        timeout_lim_i        = '0;

        // Reset state
        tick(2);
        chk("rst_ready", job_if.req_ready_o, 0);
        chk("rst_start", cnt_start_o, 0);
        chk("rst_val", cnt_val_o, 0);
        chk("rst_rsp_valid", job_if.rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_ready", job_if.req_ready_o, 1);

        // Single job, done 6 cycles after start
        m_dly = 6;
        send(3, 5, 6, 0, 1, 1);
        wait_all(100);

        // FIFO fill while the counter reports busy
        m_dly = 3;
        hold  = 1'b1;
        for (int i = 0; i < 4; i++) send(i, 10 + i, 3, 0, 1, 1);
        @(negedge clk);
        chk("full_ready_low", job_if.req_ready_o, 0);
        job_if.req_valid_i   = 1'b1;
        job_if.req_id_i      = 4'd4;
        job_if.req_cnt_val_i = 7'd14;
        exp_rsp.push_back('{id: 4'd4, cycles: 16'd3, tmo: 1'b0});
        exp_val.push_back(7'd14);
        @(negedge clk);
        chk("full_ready_hold", job_if.req_ready_o, 0);
        chk("full_busy", busy_o, 1);
        @(posedge clk);
        #1;
        hold = 1'b0;
        @(negedge clk);
        chk("ready_before_pop", job_if.req_ready_o, 0);
        @(negedge clk);
        chk("ready_after_pop", job_if.req_ready_o, 1);
        @(posedge clk);
        #1;
        job_if.req_valid_i = 1'b0;
        wait_all(300);

        // Watchdog: the counter outlives the limit, next launch waits for idle
        timeout_lim_i = 16'd10;
        m_dly = 40;
        s0 = n_starts;
        send(7, 20, 10, 1, 1, 1);
        send(8, 21, 10, 1, 1, 1);
        n = 0;
        while (exp_rsp.size() > 1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        tick(15);
        chk("no_launch_while_busy", n_starts, s0 + 1);
        wait_all(300);

        // Done versus limit: collision, just before, just after
        timeout_lim_i = 16'd4;
        m_dly = 4;
        send(9, 1, 4, 0, 1, 1);
        wait_all(200);
        m_dly = 3;
        send(10, 2, 3, 0, 1, 1);
        wait_all(200);
        m_dly = 5;
        send(11, 3, 4, 1, 1, 1);
        wait_all(200);

        // Response backpressure with a second job queued
        timeout_lim_i = '0;
        m_dly = 2;
        job_if.rsp_ready_i = 1'b0;
        tick(10);
        s0 = n_starts;
        send(1, 0, 2, 0, 1, 1);
        send(2, 33, 2, 0, 1, 1);
        n = 0;
        while (!job_if.rsp_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_valid", job_if.rsp_valid_o, 1);
            chk("bp_id", job_if.rsp_id_o, 1);
            chk("bp_cycles", job_if.rsp_cycles_o, 2);
            chk("bp_no_start", n_starts, s0 + 1);
        end
        @(posedge clk);
        #1;
        job_if.rsp_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_start_gap1", cnt_start_o, 0);
        @(negedge clk);
        chk("bp_start_gap2", cnt_start_o, 1);
        wait_all(100);

        // Reset in the middle of WAIT with jobs queued
        m_dly = 30;
        s0 = n_starts;
        send(5, 7, 0, 0, 0, 1);
        send(6, 8, 0, 0, 0, 0);
        send(12, 9, 0, 0, 0, 0);
        n = 0;
        while (n_starts == s0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_start", cnt_start_o, 0);
        chk("mid_rst_val", cnt_val_o, 0);
        chk("mid_rst_ready", job_if.req_ready_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_rsp", job_if.rsp_valid_o, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("rel_ready", job_if.req_ready_o, 1);
        chk("rel_busy", busy_o, 0);
        tick(40);
        chk("rel_no_start", n_starts, s0 + 1);
        chk("rel_queues", exp_rsp.size() + exp_val.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_job_issuer.md
Name: counter_job_issuer

Overview:
Initiator side of the counter start/done interface. It accepts count jobs from a requester over a valid/ready channel and buffers them in a small FIFO. It launches each job on a downstream counter (start pulse plus count value), waits for that counter's done, then returns a response carrying the job id, elapsed cycles and a timeout flag. It sits between the control logic and a counter block (idle/run/done outputs, start/cnt_val inputs).

Parameters:
CNT_WIDTH, 7, width of count value driven to counter
ID_WIDTH, 4, width of job tag
DEPTH, 4, job FIFO entries (power of 2, >=2)
TO_WIDTH, 16, width of cycle counter and timeout limit

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid_i  in  1  job request valid
req_ready_o  out  1  FIFO can accept job
req_cnt_val_i  in  CNT_WIDTH  job count target
req_id_i  in  ID_WIDTH  job tag
timeout_lim_i  in  TO_WIDTH  WAIT-cycle limit; 0 = watchdog disabled
cnt_start_o  out  1  one-cycle start pulse to counter
cnt_val_o  out  CNT_WIDTH  count target to counter, registered
cnt_idle_i  in  1  counter idle
cnt_run_i  in  1  counter running (status only)
cnt_done_i  in  1  counter done
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_id_o  out  ID_WIDTH  tag of completed job
rsp_cycles_o  out  TO_WIDTH  elapsed cycles
rsp_timeout_o  out  1  1 = job ended by watchdog
busy_o  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst=1): FSM->IDLE; FIFO emptied; all outputs 0, including req_ready_o. From the first cycle after deassertion, req_ready_o=1.
- FIFO: push on req_valid_i & req_ready_o. req_ready_o = !full, from registered state only. When full, no push, even if a pop occurs in the same cycle; ready rises the next cycle. Pointers wrap modulo DEPTH. Separate full/empty tracking is required (count or extra pointer bit).
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if FIFO non-empty and cnt_idle_i=1, pop the head and latch id/val -> LAUNCH. Otherwise stay in IDLE.
- LAUNCH (1 cycle): cnt_start_o=1; cnt_val_o holds the latched value from this cycle until the next launch; cycle counter cleared to 0 -> WAIT.
- WAIT: cycle counter increments each cycle and saturates at all-ones.
  - cnt_done_i=1: rsp_cycles = counter+1 (done on the first WAIT cycle gives 1), timeout=0 -> RESP.
  - Else if timeout_lim_i!=0 and counter+1 == timeout_lim_i: timeout=1, cycles=timeout_lim_i -> RESP.
  - Done and limit in the same cycle: done wins, timeout=0.
- RESP: rsp_valid_o=1 with id/cycles/timeout stable until rsp_valid_o & rsp_ready_i, then -> IDLE. No new launch while in RESP.
- After a timeout the counter is not aborted. IDLE blocks the next launch until cnt_idle_i=1.
- cnt_done_i outside WAIT is ignored. cnt_run_i is unused except for optional assertions.
- cnt_val_o = 0 is legal; it is issued unchanged.
- Minimum job period is 4 cycles (IDLE, LAUNCH, WAIT, RESP with immediate ready).
- Reset mid-job: queued and in-flight jobs are discarded with no response; cnt_start_o drops immediately.

Decomposition:
- Shared package counter_pkg: FSM state encodings (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3) and default CNT_WIDTH.
- Sub-module counter_job_fifo (parameters DEPTH, data width ID_WIDTH+CNT_WIDTH; push/pop/full/empty).
- The FSM, cycle counter and response registers stay in counter_job_issuer.

Test Plan:
- Reset then single job: id=3, val=5; counter model asserts done 6 cycles after start, timeout_lim=0 -> one start pulse with cnt_val_o=5; rsp id=3, cycles=6, timeout=0.
- FIFO fill: 5 back-to-back requests (ids 0-4) with counter idle=0 -> ready low after 4 accepts; id 4 accepted the cycle after the first pop; responses return in order 0-4.
- Watchdog: timeout_lim=10, counter never asserts done -> rsp cycles=10, timeout=1. The next job launches only after cnt_idle_i returns to 1.
- Done/limit collision: timeout_lim=4, done on the 4th WAIT cycle -> cycles=4, timeout=0.
- Response backpressure: rsp_ready_i low for 7 cycles with 2 jobs queued -> rsp fields stable and no second start until the handshake; second start 2 cycles after the handshake.
- Async reset asserted mid-WAIT with 2 jobs queued -> outputs 0 immediately; after release, req_ready_o=1, busy_o=0, no response or start emitted.
